// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundles the CPU port, DMA port and synchronous-RAM port of the memory
// arbiter. The clock and reset stay plain ports on the arbiter.
//   slave  : arbiter side (takes requests, drives memory strobes/acks)
//   master : requester/memory side (testbench or surrounding system)
//   CPU    : cpu_req, cpu_we, cpu_addr[15:0], cpu_wdata[15:0] -> cpu_ack, cpu_rdata[15:0]
//   DMA    : dma_req, dma_we, dma_lock, dma_addr[15:0], dma_wdata[15:0] -> dma_ack, dma_rdata[15:0]
//   Memory : mem_addr[15:0], mem_wdata[15:0], mem_re, mem_we -> mem_rdata[15:0]
//   Status : busy
interface mem_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;

    logic        dma_req;
    logic        dma_we;
    logic        dma_lock;
    logic [15:0] dma_addr;
    logic [15:0] dma_wdata;
    logic        dma_ack;
    logic [15:0] dma_rdata;

    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_re;
    logic        mem_we;
    logic [15:0] mem_rdata;

    logic        busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
        output dma_ack, dma_rdata,
        output mem_addr, mem_wdata, mem_re, mem_we,
        input  mem_rdata,
        output busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
        input  dma_ack, dma_rdata,
        input  mem_addr, mem_wdata, mem_re, mem_we,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Two-port (CPU, DMA) arbiter in front of a single synchronous RAM.
// Each access is IDLE -> ACCESS -> DONE; the winner's operands are latched
// at grant, the RAM is strobed in ACCESS and the owner is acked in DONE.
// A DMA holding dma_lock chains up to 16 accesses back to back (DONE -> ACCESS).
//
// Ports:
//   clk   : sole clock, rising edge
//   reset : synchronous, active-high
//   bus   : mem_arbiter_if.slave (CPU, DMA and RAM signals, busy)
//
// Build option:
//   MEM_ARB_ROUND_ROBIN_EN defined   -> IDLE ties go to the port that did not
//                                       own the previous grant
//   MEM_ARB_ROUND_ROBIN_EN undefined -> IDLE ties always go to the CPU
//
// state  | meaning
// IDLE   | no access in flight, arbitrate on requests
// ACCESS | RAM strobed with latched operands (one cycle)
// DONE   | owner acked, read data captured, maybe re-lock to DMA
module mem_arbiter (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef enum logic {OWN_CPU, OWN_DMA} owner_t;

    state_t      state, state_nxt;
    owner_t      owner;
    logic        lat_we;
    logic [15:0] lat_addr;
    logic [15:0] lat_wdata;
    logic [3:0]  burst_cnt;
    logic [15:0] cpu_rdata_q;
    logic [15:0] dma_rdata_q;
    logic        grant;
    logic        grant_dma;
    logic        relock;
    logic        done_rd;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    owner_t      last_owner;
`endif

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        grant_dma = 1'b0;
        relock    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cpu_req || bus.dma_req) begin
                    grant     = 1'b1;
                    state_nxt = ACCESS;
                    if (bus.cpu_req && bus.dma_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        grant_dma = (last_owner == OWN_CPU);
`else
                        grant_dma = 1'b0;
`endif
                    end else begin
                        grant_dma = bus.dma_req;
                    end
                end
            end
            ACCESS: state_nxt = DONE;
            DONE: begin
                // Lock chaining ignores cpu_req; burst_cnt caps the chain at 16.
                if (owner == OWN_DMA && bus.dma_req && bus.dma_lock && burst_cnt != 4'hF) begin
                    relock    = 1'b1;
                    state_nxt = ACCESS;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= OWN_CPU;
            lat_we      <= 1'b0;
            lat_addr    <= 16'h0000;
            lat_wdata   <= 16'h0000;
            burst_cnt   <= 4'h0;
            cpu_rdata_q <= 16'h0000;
            dma_rdata_q <= 16'h0000;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_owner  <= OWN_DMA;
`endif
        end else begin
            state <= state_nxt;
            if (grant) begin
                owner     <= grant_dma ? OWN_DMA : OWN_CPU;
                lat_we    <= grant_dma ? bus.dma_we    : bus.cpu_we;
                lat_addr  <= grant_dma ? bus.dma_addr  : bus.cpu_addr;
                lat_wdata <= grant_dma ? bus.dma_wdata : bus.cpu_wdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                last_owner <= grant_dma ? OWN_DMA : OWN_CPU;
`endif
            end
            if (relock) begin
                lat_we    <= bus.dma_we;
                lat_addr  <= bus.dma_addr;
                lat_wdata <= bus.dma_wdata;
                burst_cnt <= burst_cnt + 4'd1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                last_owner <= OWN_DMA;
`endif
            end else if (state_nxt == IDLE) begin
                burst_cnt <= 4'h0;
            end
            if (done_rd) begin
                if (owner == OWN_CPU) cpu_rdata_q <= bus.mem_rdata;
                else                  dma_rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign done_rd = (state == DONE) && !lat_we;

    assign bus.mem_addr  = lat_addr;
    assign bus.mem_wdata = lat_wdata;
    assign bus.mem_we    = (state == ACCESS) &&  lat_we;
    assign bus.mem_re    = (state == ACCESS) && !lat_we;
    assign bus.busy      = (state != IDLE);

    // Acks are masked by reset so an access aborted in DONE is never acknowledged.
    assign bus.cpu_ack = (state == DONE) && (owner == OWN_CPU) && !reset;
    assign bus.dma_ack = (state == DONE) && (owner == OWN_DMA) && !reset;

    // RAM data only arrives in DONE, so bypass it to the owner alongside the ack;
    // the register keeps it afterwards.
    assign bus.cpu_rdata = (done_rd && owner == OWN_CPU) ? bus.mem_rdata : cpu_rdata_q;
    assign bus.dma_rdata = (done_rd && owner == OWN_DMA) ? bus.mem_rdata : dma_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    logic clk;
    logic reset;
    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int cpu_ack_cnt = 0;
    int dma_ack_cnt = 0;

    logic [15:0] ram [0:1023];
    logic [15:0] ref_mem [0:15];

    // Synchronous RAM model: read data appears the cycle after mem_re.
    always @(posedge clk) begin
        if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_addr[9:0]];
        if (bus.mem_we) ram[bus.mem_addr[9:0]] = bus.mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("re_we_exclusive", {31'b0, bus.mem_re & bus.mem_we}, 32'd0);
            chk("acks_exclusive", {31'b0, bus.cpu_ack & bus.dma_ack}, 32'd0);
            if (bus.cpu_ack) cpu_ack_cnt++;
            if (bus.dma_ack) dma_ack_cnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated access with exact-latency checks: ACCESS at N+1, ack at N+2, IDLE after.
    task automatic iso(input bit is_dma, input bit we, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic [15:0] exp_rd);
        if (is_dma) begin
            bus.dma_we = we; bus.dma_addr = addr; bus.dma_wdata = wdata; bus.dma_req = 1'b1;
        end else begin
            bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata; bus.cpu_req = 1'b1;
        end
        tick();
        chk("acc_mem_we", {31'b0, bus.mem_we}, {31'b0, we});
        chk("acc_mem_re", {31'b0, bus.mem_re}, {31'b0, !we});
        chk("acc_mem_addr", {16'b0, bus.mem_addr}, {16'b0, addr});
        if (we) chk("acc_mem_wdata", {16'b0, bus.mem_wdata}, {16'b0, wdata});
        chk("acc_busy", {31'b0, bus.busy}, 32'd1);
        chk("acc_no_ack", {30'b0, bus.cpu_ack, bus.dma_ack}, 32'd0);
        tick();
        chk("done_owner_ack", {31'b0, is_dma ? bus.dma_ack : bus.cpu_ack}, 32'd1);
        chk("done_other_ack", {31'b0, is_dma ? bus.cpu_ack : bus.dma_ack}, 32'd0);
        chk("done_strobes", {30'b0, bus.mem_re, bus.mem_we}, 32'd0);
        if (!we) chk("done_rdata", {16'b0, is_dma ? bus.dma_rdata : bus.cpu_rdata}, {16'b0, exp_rd});
        bus.cpu_req = 1'b0;
        bus.dma_req = 1'b0;
        tick();
        chk("post_idle_busy", {31'b0, bus.busy}, 32'd0);
        chk("post_idle_acks", {30'b0, bus.cpu_ack, bus.dma_ack}, 32'd0);
    endtask

    task automatic start_cpu();
        bus.cpu_we    = 1'($urandom_range(0, 1));
        bus.cpu_addr  = 16'h0200 + 16'($urandom_range(0, 7));
        bus.cpu_wdata = 16'($urandom);
        bus.cpu_req   = 1'b1;
    endtask

    task automatic start_dma();
        bus.dma_we    = 1'($urandom_range(0, 1));
        bus.dma_addr  = 16'h0208 + 16'($urandom_range(0, 7));
        bus.dma_wdata = 16'($urandom);
        bus.dma_lock  = 1'($urandom_range(0, 1));
        bus.dma_req   = 1'b1;
    endtask

    initial begin
        int order [3];
        int exp_order [3];
        int n;
        int nd;
        int last_d;
        int t16;
        int cpu_t;
        bit done37;
        int c_left;
        int d_left;
        bit c_act;
        bit d_act;
        int snap_c;
        int snap_d;

        for (int i = 0; i < 1024; i++) ram[i] = 16'h0000;
        for (int i = 0; i < 16; i++) ref_mem[i] = 16'h0000;
        ram[16'h0010] = 16'hBEEF;
        ram[16'h0040] = 16'h4444;
        ram[16'h0050] = 16'h5555;

        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.dma_req = 0; bus.dma_we = 0; bus.dma_lock = 0; bus.dma_addr = 0; bus.dma_wdata = 0;
        reset = 1'b1;
        tick();
        tick();
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_acks", {30'b0, bus.cpu_ack, bus.dma_ack}, 32'd0);
        chk("rst_strobes", {30'b0, bus.mem_re, bus.mem_we}, 32'd0);
        chk("rst_cpu_rdata", {16'b0, bus.cpu_rdata}, 32'h0000);
        chk("rst_dma_rdata", {16'b0, bus.dma_rdata}, 32'h0000);
        chk("rst_mem_addr", {16'b0, bus.mem_addr}, 32'h0000);
        reset = 1'b0;

        // CPU read of preloaded RAM, then CPU write, then DMA read-back.
        iso(1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF);
        chk("cpu_rdata_hold", {16'b0, bus.cpu_rdata}, 32'hBEEF);
        iso(1'b0, 1'b1, 16'h0030, 16'h1234, 16'h0000);
        chk("ram_after_write", {16'b0, ram[16'h0030]}, 32'h1234);
        chk("cpu_rdata_kept_on_write", {16'b0, bus.cpu_rdata}, 32'hBEEF);
        iso(1'b1, 1'b0, 16'h0030, 16'h0000, 16'h1234);
        chk("cpu_rdata_kept_on_dma", {16'b0, bus.cpu_rdata}, 32'hBEEF);
        iso(1'b1, 1'b1, 16'h0031, 16'h00A5, 16'h0000);
        chk("dma_rdata_kept_on_write", {16'b0, bus.dma_rdata}, 32'h1234);

        // Simultaneous requests straight after reset.
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        bus.cpu_we = 0; bus.cpu_addr = 16'h0040; bus.cpu_req = 1;
        bus.dma_we = 0; bus.dma_addr = 16'h0050; bus.dma_lock = 0; bus.dma_req = 1;
        n = 0;
        for (int c = 0; c < 40 && n < 3; c++) begin
            tick();
            if (bus.cpu_ack) begin
                chk("tie_cpu_rdata", {16'b0, bus.cpu_rdata}, 32'h4444);
                order[n] = 0;
                n++;
            end else if (bus.dma_ack) begin
                chk("tie_dma_rdata", {16'b0, bus.dma_rdata}, 32'h5555);
                order[n] = 1;
                n++;
            end
        end
        bus.cpu_req = 0;
        bus.dma_req = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 0};
`else
        exp_order = '{0, 0, 0};
`endif
        chk("tie_ack_count", n, 3);
        for (int i = 0; i < 3; i++) chk($sformatf("tie_order_%0d", i), order[i], exp_order[i]);
        tick();
        tick();

        // Locked DMA burst of 20 writes with the CPU waiting.
        bus.dma_we = 1; bus.dma_lock = 1; bus.dma_addr = 16'h0100; bus.dma_wdata = 16'hD000;
        bus.dma_req = 1;
        nd = 0; last_d = 0; t16 = 0; cpu_t = -1; done37 = 0;
        for (int c = 1; c <= 200 && !done37; c++) begin
            tick();
            if (c == 1) begin
                bus.cpu_we = 0; bus.cpu_addr = 16'h0010; bus.cpu_req = 1;
            end
            if (bus.dma_ack) begin
                nd++;
                if ((nd >= 2 && nd <= 16) || nd >= 18) chk("burst_gap", c - last_d, 2);
                if (nd == 16) t16 = c;
                if (nd == 17) chk("dma_resume_time", c, cpu_t + 3);
                last_d = c;
                if (nd < 20) begin
                    bus.dma_addr  = 16'h0100 + 16'(nd);
                    bus.dma_wdata = 16'hD000 + 16'(nd);
                end else begin
                    bus.dma_req  = 0;
                    bus.dma_lock = 0;
                end
            end
            if (bus.cpu_ack) begin
                chk("cpu_after_16_dma", nd, 16);
                chk("cpu_grant_time", c, t16 + 3);
                chk("cpu_burst_rdata", {16'b0, bus.cpu_rdata}, 32'hBEEF);
                cpu_t = c;
                bus.cpu_req = 0;
            end
            if (nd == 20 && cpu_t > 0) done37 = 1;
        end
        chk("burst_complete", {31'b0, done37}, 32'd1);
        tick();
        chk("burst_idle", {31'b0, bus.busy}, 32'd0);
        for (int i = 0; i < 20; i++)
            chk($sformatf("burst_ram_%0d", i), {16'b0, ram[16'h0100 + i]}, {16'b0, 16'hD000 + 16'(i)});

        // Reset in the ACCESS cycle of a CPU write, DMA request held through reset.
        ram[16'h0010] = 16'hBEEF;
        bus.cpu_we = 1; bus.cpu_addr = 16'h0020; bus.cpu_wdata = 16'hAAAA; bus.cpu_req = 1;
        tick();
        chk("abort_in_access", {31'b0, bus.mem_we}, 32'd1);
        reset = 1'b1;
        bus.cpu_req = 0;
        bus.dma_we = 0; bus.dma_addr = 16'h0010; bus.dma_lock = 0; bus.dma_req = 1;
        snap_c = cpu_ack_cnt;
        tick();
        chk("abort_mem_we", {31'b0, bus.mem_we}, 32'd0);
        chk("abort_busy", {31'b0, bus.busy}, 32'd0);
        chk("abort_acks", {30'b0, bus.cpu_ack, bus.dma_ack}, 32'd0);
        reset = 1'b0;
        tick();
        chk("rearb_mem_re", {31'b0, bus.mem_re}, 32'd1);
        chk("rearb_addr", {16'b0, bus.mem_addr}, 32'h0010);
        tick();
        chk("rearb_dma_ack", {31'b0, bus.dma_ack}, 32'd1);
        chk("rearb_dma_rdata", {16'b0, bus.dma_rdata}, 32'hBEEF);
        chk("abort_no_cpu_ack", cpu_ack_cnt - snap_c, 0);
        bus.dma_req = 0;
        tick();

        // Random back-to-back traffic; CPU owns 0x200-0x207, DMA owns 0x208-0x20F.
        c_left = 30; d_left = 30;
        snap_c = cpu_ack_cnt; snap_d = dma_ack_cnt;
        start_cpu(); c_act = 1; c_left--;
        start_dma(); d_act = 1; d_left--;
        for (int c = 0; c < 3000 && (c_act || d_act); c++) begin
            tick();
            if (bus.cpu_ack) begin
                chk("rnd_cpu_ack_expected", {31'b0, c_act}, 32'd1);
                if (!bus.cpu_we) chk("rnd_cpu_rdata", {16'b0, bus.cpu_rdata}, {16'b0, ref_mem[bus.cpu_addr[3:0]]});
                else ref_mem[bus.cpu_addr[3:0]] = bus.cpu_wdata;
                c_act = 0;
                bus.cpu_req = 0;
                if (c_left > 0) begin start_cpu(); c_act = 1; c_left--; end
            end
            if (bus.dma_ack) begin
                chk("rnd_dma_ack_expected", {31'b0, d_act}, 32'd1);
                if (!bus.dma_we) chk("rnd_dma_rdata", {16'b0, bus.dma_rdata}, {16'b0, ref_mem[bus.dma_addr[3:0]]});
                else ref_mem[bus.dma_addr[3:0]] = bus.dma_wdata;
                d_act = 0;
                bus.dma_req = 0;
                bus.dma_lock = 0;
                if (d_left > 0) begin start_dma(); d_act = 1; d_left--; end
            end
        end
        chk("rnd_all_done", {30'b0, c_act, d_act}, 32'd0);
        tick();
        tick();
        chk("rnd_cpu_ack_total", cpu_ack_cnt - snap_c, 30);
        chk("rnd_dma_ack_total", dma_ack_cnt - snap_d, 30);
        chk("rnd_final_idle", {31'b0, bus.busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
